// File: rtl/echo_pkg.sv
// Shared constants for the echo engine: feedback mode encoding and gain format.
package echo_pkg;

  typedef enum logic {
    ECHO_FF = 1'b0,
    ECHO_FB = 1'b1
  } echo_mode_e;

  // beta is a gain in quarters, so the product is shifted right by two.
  localparam int BETA_W     = 2;
  localparam int GAIN_SHIFT = 2;

endpackage

// File: rtl/echo_if.sv
// Sample-stream bundle between a controller and the echo engine.
interface echo_if #(
  parameter int SIZE      = 8,
  parameter int ADDR_SIZE = 11
) ();

  logic                        en;
  logic                        mode;
  logic [ADDR_SIZE-1:0]        delay;
  logic [echo_pkg::BETA_W-1:0] beta;
  logic [SIZE-1:0]             sound;
  logic [SIZE-1:0]             echo;
  logic                        echo_valid;

  modport master (
    output en, mode, delay, beta, sound,
    input  echo, echo_valid
  );

  modport slave (
    input  en, mode, delay, beta, sound,
    output echo, echo_valid
  );

endinterface

// File: rtl/echo_ram.sv
// Delay-line storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the write enable is the only flow control.
module echo_ram #(
  parameter int SIZE      = 8,
  parameter int ADDR_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [SIZE-1:0]      wr_dat,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [SIZE-1:0]      rd_dat
);

  logic [SIZE-1:0] mem [2**ADDR_SIZE];

  // No reset on the array; the engine's fill counter keeps stale words out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/echo_engine.sv
// Echo generator: adds a beta-scaled, delay-tick-old sample to the input, feedforward or recirculating.
// Latency: one clock from sample tick to echo/echo_valid.
// Backpressure: none; en low freezes divider, pointers, memory and output.
module echo_engine
  import echo_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int ADDR_SIZE = 11,
  parameter int DIV       = 1
) (
  input  logic clk,
  input  logic rst,
  echo_if.slave bus
);

  localparam int          SUM_W    = SIZE + 2;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic [15:0]          div_cnt;
  logic                 tick;
  logic [ADDR_SIZE-1:0] wp;
  logic [ADDR_SIZE-1:0] fill;
  logic [ADDR_SIZE-1:0] prev_delay;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] fill_base;
  logic [ADDR_SIZE-1:0] fill_next;
  logic [SIZE-1:0]      ram_rd_dat;
  logic [SIZE-1:0]      tap;
  logic [SIZE-1:0]      sum_sat;
  logic [SIZE-1:0]      wr_dat;
  logic [SUM_W-1:0]     prod;
  logic [SUM_W-1:0]     scaled;
  logic [SUM_W-1:0]     sum_w;
  logic [SIZE-1:0]      echo_q;
  logic                 echo_vld_q;

  assign tick = bus.en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (bus.en) begin
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
    end
  end

  // A new delay restarts the fill count on the tick that sees it, so words
  // written under the old delay are never treated as valid history.
  always_comb begin
    fill_base = (bus.delay != prev_delay) ? '0 : fill;
    fill_next = (&fill_base) ? fill_base : fill_base + 1'b1;
    rd_addr   = wp - bus.delay;
    tap       = '0;
    if ((bus.delay != '0) && (fill_base >= bus.delay)) begin
      tap = ram_rd_dat;
    end
  end

  always_comb begin
    prod    = SUM_W'(tap) * SUM_W'(bus.beta);
    scaled  = prod >> GAIN_SHIFT;
    sum_w   = SUM_W'(bus.sound) + scaled;
    sum_sat = (sum_w[SUM_W-1:SIZE] != '0) ? {SIZE{1'b1}} : sum_w[SIZE-1:0];
    wr_dat  = (bus.mode == ECHO_FB) ? sum_sat : bus.sound;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= '0;
      fill       <= '0;
      prev_delay <= '0;
    end else if (tick) begin
      wp         <= wp + 1'b1;
      fill       <= fill_next;
      prev_delay <= bus.delay;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_q     <= '0;
      echo_vld_q <= 1'b0;
    end else begin
      echo_vld_q <= tick;
      if (tick) begin
        echo_q <= sum_sat;
      end
    end
  end

  assign bus.echo       = echo_q;
  assign bus.echo_valid = echo_vld_q;

  echo_ram #(
    .SIZE      (SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .we      (tick),
    .wr_addr (wp),
    .wr_dat  (wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (ram_rd_dat)
  );

endmodule

// File: tb/tb_echo_engine.sv
// Directed bench: two engines (DIV=1 and DIV=4), expected echoes queued at drive time.
module tb_echo_engine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  echo_if #(.SIZE(8), .ADDR_SIZE(4)) b1 ();
  echo_if #(.SIZE(8), .ADDR_SIZE(4)) b4 ();

  echo_engine #(.SIZE(8), .ADDR_SIZE(4), .DIV(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  echo_engine #(.SIZE(8), .ADDR_SIZE(4), .DIV(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int last4 = -1;

  logic [7:0] q1 [$];
  logic [7:0] q4 [$];
  int         gq [$];

  logic [7:0] s4 [19] = '{100, 0, 0, 0, 0, 0, 40, 40, 40, 40, 40, 30, 0, 0, 0, 0, 0, 0, 0};
  logic [7:0] e4 [19] = '{100, 0, 0, 50, 0, 0, 40, 40, 40, 60, 60, 30, 0, 0, 0, 0, 15, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b1.echo_valid === 1'b1) begin
      chk("dut1_valid_expected", q1.size() != 0, 1);
      if (q1.size() != 0) chk("dut1_echo", b1.echo, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b4.echo_valid === 1'b1) begin
      chk("dut4_valid_expected", q4.size() != 0, 1);
      if (q4.size() != 0) chk("dut4_echo", b4.echo, q4.pop_front());
      if (last4 >= 0 && gq.size() != 0) chk("dut4_tick_gap", cyc - last4, gq.pop_front());
      last4 = cyc;
    end
  end

  task automatic reset_pulse();
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cfg1(input logic m, input logic [3:0] d, input logic [1:0] bt);
    b1.mode  = m;
    b1.delay = d;
    b1.beta  = bt;
  endtask

  task automatic t1(input logic [7:0] snd, input logic [7:0] ex);
    b1.sound = snd;
    q1.push_back(ex);
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    b1.en    = 1'b1;
    b1.mode  = 1'b0;
    b1.delay = '0;
    b1.beta  = '0;
    b1.sound = '0;
    b4.en    = 1'b0;
    b4.mode  = 1'b0;
    b4.delay = '0;
    b4.beta  = '0;
    b4.sound = '0;

    @(negedge clk);
    chk("reset_echo1", b1.echo, 0);
    chk("reset_valid1", b1.echo_valid, 0);
    chk("reset_echo4", b4.echo, 0);
    chk("reset_valid4", b4.echo_valid, 0);

    // Feedforward impulse
    cfg1(1'b0, 4'd3, 2'd2);
    reset_pulse();
    for (int k = 0; k < 12; k++)
      t1((k == 0) ? 8'd100 : 8'd0, (k == 0) ? 8'd100 : (k == 3) ? 8'd50 : 8'd0);

    // Feedback impulse: halves every third tick
    cfg1(1'b1, 4'd3, 2'd2);
    reset_pulse();
    for (int k = 0; k < 24; k++)
      t1((k == 0) ? 8'd100 : 8'd0, (k % 3 == 0) ? 8'(100 >> (k / 3)) : 8'd0);

    // Saturation, then reset mid-stream
    cfg1(1'b0, 4'd1, 2'd3);
    reset_pulse();
    for (int k = 0; k < 6; k++)
      t1(8'd200, (k == 0) ? 8'd200 : 8'd255);
    #1 rst = 1'b0;
    #1;
    chk("midrst_echo", b1.echo, 0);
    chk("midrst_valid", b1.echo_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("release_valid_low", b1.echo_valid, 0);
    t1(8'd200, 8'd200);
    chk("first_valid_after_release", b1.echo_valid, 1);
    t1(8'd200, 8'd255);
    t1(8'd200, 8'd255);

    // Maximum delay with stale memory contents behind the fill gate
    cfg1(1'b0, 4'd15, 2'd2);
    reset_pulse();
    for (int k = 0; k < 40; k++)
      t1((k == 20) ? 8'd80 : 8'd0, (k == 20) ? 8'd80 : (k == 35) ? 8'd40 : 8'd0);
    b1.en = 1'b0;
    @(negedge clk);
    chk("q1_drain", q1.size(), 0);

    // DIV=4 engine: delay change, enable gap
    b4.mode  = 1'b0;
    b4.delay = 4'd3;
    b4.beta  = 2'd2;
    reset_pulse();
    b4.en = 1'b1;
    last4 = cyc;
    for (int k = 0; k < 19; k++) begin
      if (k == 11) b4.delay = 4'd5;
      if (k == 9) begin
        b4.en = 1'b0;
        for (int j = 0; j < 7; j++) begin
          @(negedge clk);
          chk("hold_echo", b4.echo, e4[8]);
          chk("hold_valid", b4.echo_valid, 0);
        end
        b4.en = 1'b1;
      end
      b4.sound = s4[k];
      q4.push_back(e4[k]);
      gq.push_back((k == 9) ? 11 : 4);
      repeat (4) @(negedge clk);
    end
    b4.en = 1'b0;
    @(negedge clk);
    chk("q4_drain", q4.size(), 0);
    chk("gap_drain", gq.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
